// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider with joint-operand valid/ready handshakes.
// Produces {dz, rem, quot}; quotient truncates toward zero, remainder follows the dividend sign.
module div_seq #(
  parameter int unsigned DIN0_W      = 16,
  parameter int unsigned DIN1_W      = 16,
  parameter bit          DIN0_SIGNED = 1'b0,
  parameter bit          DIN1_SIGNED = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DIN0_W-1:0]        din0_data_i,
  input  logic                     din0_valid_i,
  output logic                     din0_ready_o,
  input  logic [DIN1_W-1:0]        din1_data_i,
  input  logic                     din1_valid_i,
  output logic                     din1_ready_o,
  output logic [DIN0_W+DIN1_W:0]   dout_data_o,
  output logic                     dout_valid_o,
  input  logic                     dout_ready_i
);

  localparam int unsigned CntW = $clog2(DIN0_W + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e              state_q, state_d;
  logic [DIN0_W-1:0]   quot_q, quot_d;
  logic [DIN1_W-1:0]   rem_q, rem_d;
  logic [DIN1_W-1:0]   dvs_q, dvs_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                neg_quot_q, neg_quot_d;
  logic                neg_rem_q, neg_rem_d;
  logic                dz_q, dz_d;

  logic                a_neg, b_neg, din_take;
  logic [DIN0_W-1:0]   a_mag;
  logic [DIN1_W-1:0]   b_mag, dz_rem, rem_sub;
  logic [DIN1_W:0]     trial;
  logic                trial_ge;
  logic [DIN0_W-1:0]   quot_out;
  logic [DIN1_W-1:0]   rem_out;

  assign a_neg = DIN0_SIGNED && din0_data_i[DIN0_W-1];
  assign b_neg = DIN1_SIGNED && din1_data_i[DIN1_W-1];
  assign a_mag = a_neg ? -din0_data_i : din0_data_i;
  assign b_mag = b_neg ? -din1_data_i : din1_data_i;

  // On divide-by-zero the remainder field carries the raw dividend, resized to DIN1_W.
  if (DIN0_W >= DIN1_W) begin : g_dz_trunc
    assign dz_rem = din0_data_i[DIN1_W-1:0];
  end else begin : g_dz_ext
    assign dz_rem = {{(DIN1_W - DIN0_W){1'b0}}, din0_data_i};
  end

  // Partial remainder stays below |divisor|, so the low DIN1_W bits of the difference suffice.
  assign trial    = {rem_q, quot_q[DIN0_W-1]};
  assign trial_ge = trial >= {1'b0, dvs_q};
  assign rem_sub  = trial[DIN1_W-1:0] - dvs_q;

  always_comb begin
    state_d    = state_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    cnt_d      = cnt_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    din_take   = 1'b0;
    unique case (state_q)
      StIdle: begin
        din_take = din0_valid_i & din1_valid_i;
        if (din_take) begin
          dvs_d = b_mag;
          if (din1_data_i == '0) begin
            dz_d       = 1'b1;
            quot_d     = '1;
            rem_d      = dz_rem;
            neg_quot_d = 1'b0;
            neg_rem_d  = 1'b0;
            state_d    = StDone;
          end else begin
            dz_d       = 1'b0;
            quot_d     = a_mag;
            rem_d      = '0;
            neg_quot_d = a_neg ^ b_neg;
            neg_rem_d  = a_neg;
            cnt_d      = CntW'(DIN0_W);
            state_d    = StCalc;
          end
        end
      end
      StCalc: begin
        // Dividend bits shift out of the top of quot_q while quotient bits shift in below.
        quot_d = {quot_q[DIN0_W-2:0], trial_ge};
        rem_d  = trial_ge ? rem_sub : trial[DIN1_W-1:0];
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (dout_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      quot_q     <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      cnt_q      <= cnt_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
    end
  end

  assign quot_out     = neg_quot_q ? -quot_q : quot_q;
  assign rem_out      = neg_rem_q ? -rem_q : rem_q;
  assign dout_data_o  = {dz_q, rem_out, quot_out};
  assign dout_valid_o = (state_q == StDone);
  assign din0_ready_o = din_take & ~rst;
  assign din1_ready_o = din_take & ~rst;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: three 8-bit instances (unsigned, signed, dividend-only signed) in lockstep,
// checked every cycle against a transaction-level model plus directed literal expectations.
module tb_div_seq;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  logic v0, v1, dready;
  logic [W-1:0] d0, d1;

  logic [2*W:0] dout_data [3];
  logic         dout_valid [3];
  logic         rdy0 [3];
  logic         rdy1 [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Model state
  bit           m_busy = 1'b0;
  int           m_due = 0;
  logic [2*W:0] m_exp [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_seq #(.DIN0_W(W), .DIN1_W(W), .DIN0_SIGNED(1'b0), .DIN1_SIGNED(1'b0)) u_uns (
    .clk(clk), .rst(rst),
    .din0_data_i(d0), .din0_valid_i(v0), .din0_ready_o(rdy0[0]),
    .din1_data_i(d1), .din1_valid_i(v1), .din1_ready_o(rdy1[0]),
    .dout_data_o(dout_data[0]), .dout_valid_o(dout_valid[0]), .dout_ready_i(dready)
  );

  div_seq #(.DIN0_W(W), .DIN1_W(W), .DIN0_SIGNED(1'b1), .DIN1_SIGNED(1'b1)) u_sgn (
    .clk(clk), .rst(rst),
    .din0_data_i(d0), .din0_valid_i(v0), .din0_ready_o(rdy0[1]),
    .din1_data_i(d1), .din1_valid_i(v1), .din1_ready_o(rdy1[1]),
    .dout_data_o(dout_data[1]), .dout_valid_o(dout_valid[1]), .dout_ready_i(dready)
  );

  div_seq #(.DIN0_W(W), .DIN1_W(W), .DIN0_SIGNED(1'b1), .DIN1_SIGNED(1'b0)) u_mix (
    .clk(clk), .rst(rst),
    .din0_data_i(d0), .din0_valid_i(v0), .din0_ready_o(rdy0[2]),
    .din1_data_i(d1), .din1_valid_i(v1), .din1_ready_o(rdy1[2]),
    .dout_data_o(dout_data[2]), .dout_valid_o(dout_valid[2]), .dout_ready_i(dready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference result using plain integer division (truncating, C semantics).
  function automatic logic [2*W:0] ref_div(input bit s0, input bit s1,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
    int ia, ib, q, r;
    ia = int'(a);
    ib = int'(b);
    if (s0 && a[W-1]) ia = ia - 256;
    if (s1 && b[W-1]) ib = ib - 256;
    if (ib == 0) return {1'b1, a, 8'hFF};
    q = ia / ib;
    r = ia % ib;
    return {1'b0, r[W-1:0], q[W-1:0]};
  endfunction

  // Per-cycle compare against the transaction model, then advance the model.
  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_rdy, exp_vld;
      exp_rdy = !rst && !m_busy && v0 && v1;
      exp_vld = m_busy && (cyc >= m_due);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("inst%0d din0_ready", i), {31'b0, rdy0[i]}, {31'b0, exp_rdy});
        chk($sformatf("inst%0d din1_ready", i), {31'b0, rdy1[i]}, {31'b0, exp_rdy});
        chk($sformatf("inst%0d dout_valid", i), {31'b0, dout_valid[i]}, {31'b0, exp_vld});
        if (exp_vld) chk($sformatf("inst%0d dout_data", i), 32'(dout_data[i]), 32'(m_exp[i]));
      end
      if (rst) begin
        m_busy = 1'b0;
      end else if (exp_rdy) begin
        m_busy   = 1'b1;
        m_due    = cyc + ((d1 == '0) ? 1 : W + 1);
        m_exp[0] = ref_div(1'b0, 1'b0, d0, d1);
        m_exp[1] = ref_div(1'b1, 1'b1, d0, d1);
        m_exp[2] = ref_div(1'b1, 1'b0, d0, d1);
      end else if (exp_vld && dready) begin
        m_busy = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer an operand pair, wait for it to be taken, then wait for the result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat,
                        output logic [2*W:0] r_uns, output logic [2*W:0] r_sgn,
                        output logic [2*W:0] r_mix);
    int hs;
    bit got;
    d0 = a; d1 = b; v0 = 1'b1; v1 = 1'b1;
    got = 1'b0;
    hs = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (rdy0[0]) begin got = 1'b1; hs = cyc; end
    end
    if (!got) chk("input handshake timeout", 32'd0, 32'd1);
    step();
    v0 = 1'b0; v1 = 1'b0;
    got = 1'b0;
    lat = -1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (dout_valid[0]) begin
        got = 1'b1;
        lat = cyc - hs;
        r_uns = dout_data[0];
        r_sgn = dout_data[1];
        r_mix = dout_data[2];
      end
    end
    if (!got) chk("output valid timeout", 32'd0, 32'd1);
    step();
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 8)
      0: return 8'h00;
      1: return 8'h80;
      2: return 8'hFF;
      3: return 8'h01;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int lat, hs_out, t0;
    bit got;
    logic [2*W:0] ru, rs, rm;

    rst = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 8'd5; d1 = 8'd3; dready = 1'b1;
    step();
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset din0_ready", {31'b0, rdy0[0]}, 32'd0);
    chk("reset dout_valid", {31'b0, dout_valid[0]}, 32'd0);
    step();
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
    step();

    // Unsigned 100/7
    run_op(8'd100, 8'd7, lat, ru, rs, rm);
    chk("100/7 latency", 32'(lat), 32'd9);
    chk("100/7 result", 32'(ru), {15'b0, 1'b0, 8'd2, 8'd14});

    // Signed cases
    run_op(8'hF9, 8'd2, lat, ru, rs, rm);
    chk("-7/2 result", 32'(rs), {15'b0, 1'b0, 8'hFF, 8'hFD});
    run_op(8'd7, 8'hFE, lat, ru, rs, rm);
    chk("7/-2 result", 32'(rs), {15'b0, 1'b0, 8'h01, 8'hFD});
    run_op(8'h80, 8'hFF, lat, ru, rs, rm);
    chk("min/-1 result", 32'(rs), {15'b0, 1'b0, 8'h00, 8'h80});

    // Divide by zero
    run_op(8'd55, 8'd0, lat, ru, rs, rm);
    chk("55/0 latency", 32'(lat), 32'd1);
    chk("55/0 result", 32'(ru), {15'b0, 1'b1, 8'd55, 8'hFF});
    run_op(8'hF0, 8'd0, lat, ru, rs, rm);
    chk("F0/0 mixed result", 32'(rm), {15'b0, 1'b1, 8'hF0, 8'hFF});

    // Backpressure on 200/3 with fresh operands kept valid
    dready = 1'b0;
    d0 = 8'd200; d1 = 8'd3; v0 = 1'b1; v1 = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (rdy0[0]) got = 1'b1;
    end
    if (!got) chk("bp input handshake timeout", 32'd0, 32'd1);
    step();
    d0 = 8'd17; d1 = 8'd5;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (dout_valid[0]) got = 1'b1;
    end
    if (!got) chk("bp output valid timeout", 32'd0, 32'd1);
    for (int k = 0; k < 6; k++) begin
      step();
      @(negedge clk);
      chk("bp hold valid", {31'b0, dout_valid[0]}, 32'd1);
      chk("bp hold data", 32'(dout_data[0]), {15'b0, 1'b0, 8'd2, 8'd66});
      chk("bp din ready", {31'b0, rdy0[0]}, 32'd0);
    end
    step();
    dready = 1'b1;
    @(negedge clk);
    hs_out = cyc;
    got = 1'b0;
    t0 = -1;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (rdy0[0]) begin got = 1'b1; t0 = cyc; end
    end
    chk("next accept cycle", 32'(t0), 32'(hs_out + 1));
    step();
    v0 = 1'b0; v1 = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (dout_valid[0]) begin
        got = 1'b1;
        chk("17/5 result", 32'(dout_data[0]), {15'b0, 1'b0, 8'd2, 8'd3});
      end
    end
    if (!got) chk("17/5 valid timeout", 32'd0, 32'd1);
    step();

    // Lone valid is never consumed
    v0 = 1'b1; v1 = 1'b0; d0 = 8'd42; d1 = 8'd6;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lone valid ready", {31'b0, rdy0[0]}, 32'd0);
      step();
    end
    v0 = 1'b0;

    // Reset in the third CALC cycle of 250/5
    d0 = 8'd250; d1 = 8'd5; v0 = 1'b1; v1 = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (rdy0[0]) got = 1'b1;
    end
    if (!got) chk("250/5 handshake timeout", 32'd0, 32'd1);
    step();
    v0 = 1'b0; v1 = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("no dout after reset", {31'b0, dout_valid[0]}, 32'd0);
      step();
    end
    run_op(8'd9, 8'd4, lat, ru, rs, rm);
    chk("9/4 latency", 32'(lat), 32'd9);
    chk("9/4 result", 32'(ru), {15'b0, 1'b0, 8'd1, 8'd2});

    // Randomized traffic, checked by the per-cycle model
    for (int k = 0; k < 2000; k++) begin
      v0     = ($urandom % 4) != 0;
      v1     = ($urandom % 4) != 0;
      d0     = pick();
      d1     = pick();
      dready = ($urandom % 10) < 7;
      rst    = ($urandom % 150) == 0;
      step();
    end
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0; dready = 1'b1;
    for (int k = 0; k < 20; k++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
